// File: rtl/msgdma_st_sink_checker_pkg.sv
// Shared types and constants for the mSGDMA stream sink checker.
//   sink_state_t : checker FSM states
//   LFSR_SEED    : backpressure LFSR reset value
//   LFSR_TAPS    : feedback mask (taps 16,14,13,11 -> bits 15,13,12,10)
//   LED_*        : bit positions inside led_status
package msgdma_sink_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } sink_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int LED_RUNNING = 0;
  localparam int LED_STICKY  = 1;
  localparam int LED_PASS    = 2;
  localparam int LED_DONE    = 3;

  // Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/msgdma_st_sink_checker_if.sv
// Avalon-ST beat handshake (readyLatency 0).
//   data  : beat payload, source -> sink
//   valid : beat present, source -> sink
//   ready : sink can take the beat this cycle, sink -> source
// master = stream source, slave = stream sink.
interface msgdma_st_sink_checker_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, valid, input  ready);
  modport slave  (input  data, valid, output ready);
endinterface

// File: rtl/msgdma_st_sink_checker_lfsr.sv
// Pseudo-random backpressure source.
//   clk, reset_n : clock, async active-low reset (LFSR returns to LFSR_SEED)
//   en           : 1 = ready follows the LFSR, 0 = ready always allowed
//   ready_o      : ready permission for the cycle AFTER the coming edge,
//                  so the parent can register it alongside its next state
// The LFSR free-runs every cycle regardless of what the parent is doing.
module st_backpressure_lfsr
  import msgdma_sink_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic ready_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  // Look ahead one step: the registered ready then equals ~lfsr_q[0].
  assign ready_o = en ? ~lfsr_d[0] : 1'b1;

endmodule

// File: rtl/msgdma_st_sink_checker.sv
// Avalon-ST sink terminating the mSGDMA memory-to-stream source. Checks that
// each accepted word follows an incrementing pattern seeded by the first beat.
//   clk, reset_n  : clock, async active-low reset
//   start         : one-cycle pulse, arms a new run from IDLE/DONE
//   bp_en         : enable LFSR-driven backpressure
//   st            : sink side of the stream handshake (ready is a flop)
//   word_count    : beats accepted this run
//   err_count     : mismatching beats, saturating
//   first_err_idx : index of first mismatch (valid when err_count != 0)
//   done, pass    : run complete / complete with no errors
//   led_status    : {done, pass, sticky_err, running}
module msgdma_st_sink_checker
  import msgdma_sink_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 32,
  parameter int EXPECT_WORDS = 256,
  parameter int ERR_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   bp_en,
  msgdma_st_sink_checker_if.slave st,
  output logic [CNT_W-1:0]       word_count,
  output logic [ERR_W-1:0]       err_count,
  output logic [CNT_W-1:0]       first_err_idx,
  output logic                   done,
  output logic                   pass,
  output logic [3:0]             led_status
);

  sink_state_t       state_q, state_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              st_ready_q, st_ready_d;

  logic              rdy_next;
  logic              xfer;
  logic              last_beat;
  logic [DATA_W-1:0] expect_word;

  st_backpressure_lfsr u_bp (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bp_en),
    .ready_o (rdy_next)
  );

  assign xfer        = st.valid & st_ready_q;
  assign last_beat   = (word_count_q == CNT_W'(EXPECT_WORDS - 1));
  // Beat i must equal seed + i; the add wraps naturally at DATA_W bits.
  assign expect_word = seed_q + DATA_W'(word_count_q);

  always_comb begin
    state_d         = state_q;
    word_count_d    = word_count_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    seed_d          = seed_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d         = S_ARMED;
          word_count_d    = '0;
          err_count_d     = '0;
          first_err_idx_d = '0;
          seed_d          = '0;
        end
      end
      S_ARMED: begin
        // First beat defines the pattern and can never mismatch.
        if (xfer) begin
          seed_d       = st.data;
          word_count_d = word_count_q + CNT_W'(1);
          state_d      = last_beat ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          word_count_d = word_count_q + CNT_W'(1);
          if (st.data != expect_word) begin
            if (err_count_q == '0) first_err_idx_d = word_count_q;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
          end
          if (last_beat) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Ready is derived from the next state so it drops on the edge that
    // takes the final beat and nothing beyond EXPECT_WORDS is accepted.
    st_ready_d = ((state_d == S_ARMED) || (state_d == S_RUN)) && rdy_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      word_count_q    <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      seed_q          <= '0;
      st_ready_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_count_q    <= word_count_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      seed_q          <= seed_d;
      st_ready_q      <= st_ready_d;
    end
  end

  // The error counter never returns to zero within a run, so it doubles
  // as the sticky error flag.
  assign st.ready      = st_ready_q;
  assign word_count    = word_count_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign done          = (state_q == S_DONE);
  assign pass          = done & (err_count_q == '0);

  assign led_status[LED_DONE]    = done;
  assign led_status[LED_PASS]    = pass;
  assign led_status[LED_STICKY]  = (err_count_q != '0);
  assign led_status[LED_RUNNING] = (state_q == S_ARMED) || (state_q == S_RUN);

endmodule

// File: doc/msgdma_st_sink_checker.md
# msgdma_st_sink_checker

Avalon-ST sink that terminates the 32-bit mSGDMA memory-to-stream source (`msgdma_0_st_source`) on the FPGA fabric side. It consumes beats with a valid/ready handshake and can inject pseudo-random backpressure. It checks every accepted word against an incrementing pattern and reports counts, the first error position and pass/fail status, including a 4-bit LED summary. The HPS fills a DDR buffer with an incrementing pattern, launches the DMA, and this block confirms that the whole read path is correct.

## Interface
Parameters:
- `DATA_W`, 32, stream data width
- `CNT_W`, 32, width of word counter and error index
- `EXPECT_WORDS`, 256, beats per run (≥1, < 2^CNT_W)
- `ERR_W`, 16, error counter width (saturating)

Ports:
- `clk`  in  1  system clock, 100 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; arms a new run
- `bp_en`  in  1  1 = LFSR-driven backpressure, 0 = ready held high while armed/running
- `st_data`  in  DATA_W  sink data
- `st_valid`  in  1  sink valid
- `st_ready`  out  1  sink ready (registered output)
- `word_count`  out  CNT_W  beats accepted this run
- `err_count`  out  ERR_W  mismatching beats, saturating
- `first_err_idx`  out  CNT_W  index of first mismatch; meaningful only when `err_count != 0`
- `done`  out  1  run complete
- `pass`  out  1  `done & (err_count == 0)`
- `led_status`  out  4  `{done, pass, sticky_err, running}`

## Operation
- State machine states: IDLE, ARMED, RUN, DONE.
- IDLE/DONE:
  - `start` clears `word_count`, `err_count`, `first_err_idx`, `sticky_err`, `done` and the seed register.
  - The state then moves to ARMED.
- ARMED: the first accepted beat is captured as `seed`, counts as index 0, never mismatches, and moves the state to RUN.
- RUN: beat i is expected to equal `seed + i`, modulo 2^DATA_W; wrap from all-ones to 0 is legal.
- Transfer = `st_valid & st_ready` in the same cycle (readyLatency 0). No transfer means no state or counter change.
- On mismatch:
  - `err_count` increments, saturating at all-ones.
  - `sticky_err` is set.
  - `first_err_idx` is loaded only if `err_count` was 0.
- `EXPECT_WORDS`-th accepted beat:
  - The state moves to DONE.
  - With `EXPECT_WORDS == 1`, ARMED goes directly to DONE.
- `start` while in ARMED or RUN is ignored. This includes `start` coincident with the final beat: that beat is counted, the state enters DONE, and `start` must be re-pulsed.
- `st_ready` is 0 in IDLE and DONE. In ARMED/RUN it equals `~lfsr[0]` when `bp_en` is 1, otherwise 1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Seed 16'hACE1 at reset.
  - Advances every cycle in every state; never reloaded by `start`.
- Beats presented while `st_ready` is 0 are not consumed; the source must hold them.

## Timing
- Reset values:
  - `st_ready` = 0, `word_count` = 0, `err_count` = 0, `first_err_idx` = 0.
  - `done` = 0, `pass` = 0, `led_status` = 4'b0000, state = IDLE, LFSR = 16'hACE1.
- Reset assertion takes effect immediately and asynchronously, including mid-run. Deassertion is synchronous to `clk`, synchronised by the parent.
- `start` at edge N: the state is ARMED and `st_ready` can be 1 from edge N+1.
- An accepted beat at edge N updates `word_count`, `err_count`, `first_err_idx` and `led_status` at edge N+1.
- Final beat at edge N:
  - `done`/`pass` assert at N+1.
  - `st_ready` is 0 from N+1; no beat beyond `EXPECT_WORDS` is ever accepted.
- `st_ready` is computed from next-state, so it is registered and glitch-free.
- Throughput: one beat per cycle with `bp_en` = 0.

## Structure
- Package `msgdma_sink_pkg` holds:
  - state enum `sink_state_t`;
  - `LFSR_SEED` = 16'hACE1;
  - `LFSR_TAPS` = 16'hB400;
  - LED bit-index constants.
- Sub-module `st_backpressure_lfsr` (ports `clk`, `reset_n`, `en`, `ready_o`) holds the LFSR and the ready qualification.
- The checker FSM and counters live in the top module.

## Test plan
- Reset, `start`, `bp_en`=0, 256 beats 0x100..0x1FF back-to-back:
  - `st_ready` stays 1 for 256 cycles;
  - `done`=`pass`=1, `word_count`=256, `led_status`=4'b1100.
- Same stream with beat 17 = 0xDEAD and beat 40 = 0xBEEF:
  - `err_count`=2, `first_err_idx`=17, `pass`=0, `led_status`=4'b1010.
- `bp_en`=1, source holds valid continuously:
  - `st_ready` matches a reference LFSR seeded 16'hACE1;
  - all 256 beats are accepted once, no drop or duplicate;
  - `pass`=1.
- Seed 0xFFFFFFFE, 4-beat run (EXPECT_WORDS=4): words FFFFFFFE, FFFFFFFF, 0, 1 give `pass`=1 (wrap).
- `start` pulsed mid-run and on the final beat:
  - run continues, `word_count` ends at 256;
  - `done`=1, state stays DONE until the next `start`.
- `reset_n` dropped at beat 100:
  - all outputs return to reset values combinationally;
  - after release, state is IDLE and `st_ready`=0 until `start`.
